// File: rtl/hwag_angle_pkg.sv
// hwag_angle_pkg
//   Shared types and helpers for the angle-channel block.
//   angle_t     : widest supported angle (ticks); narrower AW values are
//                 zero-extended into it before comparison.
//   ch_state_t  : per-channel compare FSM state.
//   in_window() : 1 when angle a lies in the update window (old_a, new_a].
package hwag_angle_pkg;

    localparam int unsigned ANGLE_W = 24;

    typedef logic [ANGLE_W-1:0] angle_t;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_ARMED  = 2'd1,
        CH_ACTIVE = 2'd2
    } ch_state_t;

    // A wrap window covers the tail of the old cycle plus the head of the
    // new one. A backward resync without a wrap matches nothing, so angles
    // already passed are never fired twice.
    function automatic logic in_window(angle_t old_a, angle_t new_a,
                                       logic wrap, angle_t a);
        logic hit;
        hit = 1'b0;
        if (wrap) begin
            hit = (a > old_a) || (a <= new_a);
        end else if (new_a > old_a) begin
            hit = (a > old_a) && (a <= new_a);
        end
        return hit;
    endfunction

endpackage

// File: rtl/hwag_angle_channels_if.sv
// hwag_angle_channels_if
//   Angle-generator to angle-channel link.
//   hwag_start  : generator locked; low holds the consumer idle.
//   tick        : one-cycle pulse per angle step.
//   tooth_edge  : one-cycle pulse per filtered tooth edge.
//   gap_point   : level, current tooth edge is the cycle origin.
//   tooth_angle : angle of the captured tooth (ACNT resync value).
//   acnt_top    : last valid angle of a cycle.
//   master = generator side, slave = angle-channel side.
interface hwag_angle_channels_if #(
    parameter int unsigned AW = 24
);
    logic          hwag_start;
    logic          tick;
    logic          tooth_edge;
    logic          gap_point;
    logic [AW-1:0] tooth_angle;
    logic [AW-1:0] acnt_top;

    modport master (
        output hwag_start, tick, tooth_edge, gap_point, tooth_angle, acnt_top
    );

    modport slave (
        input hwag_start, tick, tooth_edge, gap_point, tooth_angle, acnt_top
    );
endinterface

// File: rtl/hwag_angle_ch.sv
// hwag_angle_ch
//   One angle-compare output channel (IDLE / ARMED / ACTIVE).
//   clk, rst      : clock, synchronous active-high clear (also used for stop).
//   upd_i         : update cycle (tick or tooth edge) with window (old_i, new_i].
//   old_i, new_i  : window bounds; wrap_i marks a wrap window.
//   ena_i         : channel enable.
//   set_angle_i   : angle at which out_o goes high.
//   clr_angle_i   : angle at which out_o goes low.
//   out_o         : registered channel output.
//   set_if_o      : one-cycle pulse on a set event.
//   clr_if_o      : one-cycle pulse on a clear event.
module hwag_angle_ch
    import hwag_angle_pkg::*;
#(
    parameter int unsigned AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upd_i,
    input  logic [AW-1:0] old_i,
    input  logic [AW-1:0] new_i,
    input  logic          wrap_i,
    input  logic          ena_i,
    input  logic [AW-1:0] set_angle_i,
    input  logic [AW-1:0] clr_angle_i,
    output logic          out_o,
    output logic          set_if_o,
    output logic          clr_if_o
);

    ch_state_t state_q, state_d;
    logic      set_if_q, set_if_d;
    logic      clr_if_q, clr_if_d;
    logic      set_hit, clr_hit;

    assign set_hit = in_window(angle_t'(old_i), angle_t'(new_i), wrap_i,
                               angle_t'(set_angle_i));
    assign clr_hit = in_window(angle_t'(old_i), angle_t'(new_i), wrap_i,
                               angle_t'(clr_angle_i));

    // Only one of set/clr is looked at per state, so when both fall in one
    // window the state decides the winner and the minimum pulse is one update.
    always_comb begin
        state_d  = state_q;
        set_if_d = 1'b0;
        clr_if_d = 1'b0;
        case (state_q)
            CH_IDLE: begin
                if (ena_i) state_d = CH_ARMED;
            end
            CH_ARMED: begin
                if (!ena_i) begin
                    state_d = CH_IDLE;
                end else if (upd_i && set_hit) begin
                    state_d  = CH_ACTIVE;
                    set_if_d = 1'b1;
                end
            end
            CH_ACTIVE: begin
                if (!ena_i) begin
                    state_d = CH_IDLE;
                end else if (upd_i && clr_hit) begin
                    state_d  = CH_ARMED;
                    clr_if_d = 1'b1;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CH_IDLE;
            set_if_q <= 1'b0;
            clr_if_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            set_if_q <= set_if_d;
            clr_if_q <= clr_if_d;
        end
    end

    assign out_o    = (state_q == CH_ACTIVE);
    assign set_if_o = set_if_q;
    assign clr_if_o = clr_if_q;

endmodule

// File: rtl/hwag_angle_channels.sv
// hwag_angle_channels
//   Absolute crank-angle counter (ACNT) plus CH angle-compare channels.
//   clk, rst      : clock, synchronous active-high reset.
//   gen           : angle-generator link (start, tick, tooth edge, gap,
//                   tooth angle, cycle top).
//   ch_ena        : per-channel enable.
//   ch_set_angle  : rising-edge angles, channel i at [i*AW +: AW].
//   ch_clr_angle  : falling-edge angles, channel i at [i*AW +: AW].
//   acnt          : current angle.
//   acnt_wrap     : one-cycle pulse when ACNT returns to 0.
//   ch_out        : channel outputs.
//   ch_set_if     : per-channel set-event pulses.
//   ch_clr_if     : per-channel clear-event pulses.
module hwag_angle_channels
    import hwag_angle_pkg::*;
#(
    parameter int unsigned AW = 24,
    parameter int unsigned CH = 4
) (
    input  logic             clk,
    input  logic             rst,
    hwag_angle_channels_if.slave gen,
    input  logic [CH-1:0]    ch_ena,
    input  logic [CH*AW-1:0] ch_set_angle,
    input  logic [CH*AW-1:0] ch_clr_angle,
    output logic [AW-1:0]    acnt,
    output logic             acnt_wrap,
    output logic [CH-1:0]    ch_out,
    output logic [CH-1:0]    ch_set_if,
    output logic [CH-1:0]    ch_clr_if
);

    logic [AW-1:0] acnt_q, acnt_d;
    logic          wrap_q, wrap_d;
    logic          upd;
    logic          kill;

    assign upd  = gen.tick | gen.tooth_edge;
    assign kill = rst | ~gen.hwag_start;

    // Tooth edge outranks tick; a tick arriving with an edge is dropped.
    always_comb begin
        acnt_d = acnt_q;
        wrap_d = 1'b0;
        if (gen.tooth_edge) begin
            if (gen.gap_point) begin
                acnt_d = '0;
                wrap_d = 1'b1;
            end else begin
                acnt_d = gen.tooth_angle;
            end
        end else if (gen.tick) begin
            if (acnt_q == gen.acnt_top) begin
                acnt_d = '0;
                wrap_d = 1'b1;
            end else begin
                acnt_d = acnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            acnt_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            acnt_q <= acnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign acnt      = acnt_q;
    assign acnt_wrap = wrap_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        hwag_angle_ch #(.AW(AW)) u_ch (
            .clk         (clk),
            .rst         (kill),
            .upd_i       (upd),
            .old_i       (acnt_q),
            .new_i       (acnt_d),
            .wrap_i      (wrap_d),
            .ena_i       (ch_ena[i]),
            .set_angle_i (ch_set_angle[i*AW +: AW]),
            .clr_angle_i (ch_clr_angle[i*AW +: AW]),
            .out_o       (ch_out[i]),
            .set_if_o    (ch_set_if[i]),
            .clr_if_o    (ch_clr_if[i])
        );
    end

endmodule
